// File: rtl/affine_io_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | affine_io_ctrl_if : board switch/LED bundle for the affine-transform front |
// | end.                                              Rev 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface affine_io_ctrl_if;
  logic [9:0] SW;
  logic [7:0] LED;
  logic       Valid;
  logic       Busy;

  modport master (output SW, input LED, Valid, Busy);
  modport slave  (input SW, output LED, Valid, Busy);
endinterface

`default_nettype wire

// File: rtl/affine_io_ctrl.sv
// +----------------------------------------------------------------------------+
// | affine_io_ctrl : switch/LED operator front end; captures x1,y1 and shows   |
// | the shift-add affine transform x2,y2 on LED.      Rev 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module affine_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic     Clock,
  input  wire logic     Reset,
  affine_io_ctrl_if.slave io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_X = 3'd1,
    WAIT_Y = 3'd2,
    CALC_X = 3'd3,
    CALC_Y = 3'd4,
    SHOW_X = 3'd5,
    SHOW_Y = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      sync1_q, sync2_q;
  logic [1:0]      lvl_q, lvl_d;            // [0] strobe SW[8], [1] enable SW[9]
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic            stb_rise_q, stb_rise_d;
  logic            stb_fall_q, stb_fall_d;
  logic [7:0]      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [7:0]      led_q, led_d;
  logic            valid_q, valid_d, busy_q, busy_d;
  logic signed [9:0] sx, sy, nx, x2_full, y2_full;

  // Each debouncer counts consecutive samples that disagree with the accepted
  // level; any sample that agrees again restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[8+i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == C_DB_LAST) begin
        lvl_d[i] = sync2_q[8+i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    stb_rise_d = lvl_d[0] & ~lvl_q[0];
    stb_fall_d = ~lvl_d[0] & lvl_q[0];
  end

  always_comb begin
    sx      = {{2{x1_q[7]}}, x1_q};
    sy      = {{2{y1_q[7]}}, y1_q};
    nx      = -sx;
    x2_full = (sx >>> 1) + (sx >>> 2) + (sy >>> 1) + 10'sd20;
    y2_full = (sy >>> 1) + (sy >>> 2) + (nx >>> 1) - 10'sd20;
  end

  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    case (state_q)
      IDLE:   if (lvl_q[1]) state_d = WAIT_X;
      WAIT_X: if (stb_rise_q) begin
                x1_d    = sync2_q[7:0];
                state_d = WAIT_Y;
              end
      WAIT_Y: if (stb_rise_q) begin
                y1_d    = sync2_q[7:0];
                state_d = CALC_X;
              end
      CALC_X: begin
                x2_d    = x2_full[7:0];
                state_d = CALC_Y;
              end
      CALC_Y: begin
                y2_d    = y2_full[7:0];
                state_d = SHOW_X;
              end
      SHOW_X: if (stb_rise_q) state_d = SHOW_Y;
      SHOW_Y: if (stb_fall_q) state_d = WAIT_X;
      default: state_d = IDLE;
    endcase
    // Dropping the enable wins over any strobe event and any captured operand.
    if (!lvl_q[1]) begin
      state_d = IDLE;
      x1_d    = x1_q;
      y1_d    = y1_q;
    end

    led_d   = 8'h00;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      WAIT_X, WAIT_Y: led_d = sync2_q[7:0];
      CALC_X, CALC_Y: busy_d = 1'b1;
      SHOW_X: begin led_d = x2_d; valid_d = 1'b1; end
      SHOW_Y: begin led_d = y2_d; valid_d = 1'b1; end
      default: led_d = 8'h00;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      cnt_q      <= '0;
      stb_rise_q <= 1'b0;
      stb_fall_q <= 1'b0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      led_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= io.SW;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      cnt_q      <= cnt_d;
      stb_rise_q <= stb_rise_d;
      stb_fall_q <= stb_fall_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      led_q      <= led_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign io.LED   = led_q;
  assign io.Valid = valid_q;
  assign io.Busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_affine_io_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_affine_io_ctrl : directed scoreboard bench for affine_io_ctrl.          |
// |                                                   Rev 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_affine_io_ctrl;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] exp_q[$];

  affine_io_ctrl_if bus ();

  affine_io_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .io    (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] mx2(input int x, input int y);
    return 8'((x >>> 1) + (x >>> 2) + (y >>> 1) + 20);
  endfunction

  function automatic logic [7:0] my2(input int x, input int y);
    return 8'((y >>> 1) + (y >>> 2) + ((-x) >>> 1) - 20);
  endfunction

  task automatic wait_sig(input string tag, input bit want_busy);
    int k = 0;
    while (((want_busy ? bus.Busy : bus.Valid) !== 1'b1) && k < 40) begin
      cyc(1);
      k++;
    end
    chk(tag, {7'd0, (want_busy ? bus.Busy : bus.Valid)}, 8'd1);
  endtask

  task automatic strobe_op(input int v);
    bus.SW[7:0] = 8'(v);
    cyc(1);
    bus.SW[8] = 1'b1;
    cyc(10);
    bus.SW[8] = 1'b0;
    cyc(10);
  endtask

  // Full transform from WAIT_X with SW[8] low; optional strobe glitch in SHOW_X.
  task automatic run(input int x, input int y, input bit glitch);
    logic [7:0] ex, ey;
    strobe_op(x);
    bus.SW[7:0] = 8'(y);
    cyc(1);
    exp_q.push_back(mx2(x, y));
    exp_q.push_back(my2(x, y));
    bus.SW[8] = 1'b1;
    wait_sig("valid_x", 1'b0);
    ex = exp_q.pop_front();
    ey = exp_q.pop_front();
    chk("x2", bus.LED, ex);
    bus.SW[8] = 1'b0;
    cyc(10);
    chk("x2_after_fall", bus.LED, ex);
    if (glitch) begin
      bus.SW[8] = 1'b1;
      cyc(2);
      bus.SW[8] = 1'b0;
      cyc(10);
      chk("x2_glitch", bus.LED, ex);
    end
    bus.SW[8] = 1'b1;
    cyc(10);
    chk("y2", bus.LED, ey);
    chk("valid_y", {7'd0, bus.Valid}, 8'd1);
    bus.SW[8] = 1'b0;
    cyc(10);
    chk("wait_x_led", bus.LED, 8'(y));
    chk("wait_x_valid", {7'd0, bus.Valid}, 8'd0);
  endtask

  initial begin
    bus.SW = '0;
    cyc(3);
    chk("rst_led", bus.LED, 8'h00);
    chk("rst_valid", {7'd0, bus.Valid}, 8'd0);
    chk("rst_busy", {7'd0, bus.Busy}, 8'd0);
    Reset = 1'b0;
    cyc(2);

    for (int i = 0; i < 3; i++) strobe_op(8'h55);
    chk("idle_led", bus.LED, 8'h00);
    chk("idle_valid", {7'd0, bus.Valid}, 8'd0);

    bus.SW[9] = 1'b1;
    cyc(10);
    chk("spec_4_6_x", mx2(4, 6), 8'h1A);
    chk("spec_4_6_y", my2(4, 6), 8'hEE);
    run(4, 6, 1'b0);
    run(40, 21, 1'b0);
    run(20, 55, 1'b0);
    run(11, 2, 1'b0);
    run(4, 6, 1'b0);
    run(-8, -4, 1'b0);
    run(127, 127, 1'b1);
    run(-128, 0, 1'b0);

    // Short strobe glitch in WAIT_X must not capture.
    bus.SW[7:0] = 8'd99;
    cyc(1);
    bus.SW[8] = 1'b1;
    cyc(2);
    bus.SW[8] = 1'b0;
    cyc(10);
    run(4, 6, 1'b0);

    // Enable dropped in WAIT_Y.
    strobe_op(33);
    bus.SW[9] = 1'b0;
    cyc(10);
    chk("drop_led", bus.LED, 8'h00);
    chk("drop_valid", {7'd0, bus.Valid}, 8'd0);
    bus.SW[9] = 1'b1;
    cyc(10);
    run(4, 6, 1'b0);

    // Reset during CALC_X.
    strobe_op(50);
    bus.SW[7:0] = 8'd60;
    cyc(1);
    bus.SW[8] = 1'b1;
    wait_sig("busy", 1'b1);
    Reset = 1'b1;
    bus.SW[8] = 1'b0;
    cyc(1);
    chk("rstc_led", bus.LED, 8'h00);
    chk("rstc_valid", {7'd0, bus.Valid}, 8'd0);
    chk("rstc_busy", {7'd0, bus.Busy}, 8'd0);
    Reset = 1'b0;
    cyc(12);
    run(4, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/affine_io_ctrl.md
# affine_io_ctrl

Switch/LED front end for the affine-transform design: the device-side end of the SW/LED operator handshake. It synchronises and debounces the board switches, captures operands x1 and y1 on successive SW[8] strobes while SW[9] is high, and computes x2 = 0.75·x1 + 0.5·y1 + 20 and y2 = −0.5·x1 + 0.75·y1 − 20 with shift-add arithmetic. It then presents x2 and y2 on LED under SW[8] control. It sits between the board pins and the picomips core and can also run standalone.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples SW[8] or SW[9] needs before a level change is accepted (≥1).
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- SW     in  10  SW[9] enable, SW[8] strobe, SW[7:0] signed operand; asynchronous to Clock.
- LED    out 8  display value (see Operation).
- Valid  out 1  high while a result is on LED (SHOW_X, SHOW_Y).
- Busy   out 1  high in CALC_X, CALC_Y.

## Operation
- Input path:
  - 2-flop synchroniser on all 10 SW bits.
  - SW[8] and SW[9] each have their own debouncer: a counter that reloads on any change and accepts the new level after DEBOUNCE_CYCLES equal samples.
  - stb_rise and stb_fall are single-cycle pulses taken from the debounced SW[8].
  - SW[7:0] is used post-synchroniser only (no debounce).
- FSM states: IDLE, WAIT_X, WAIT_Y, CALC_X, CALC_Y, SHOW_X, SHOW_Y.
  - IDLE: LED=0. Debounced SW[9]=1 → WAIT_X.
  - WAIT_X: LED=synced SW[7:0]. stb_rise → x1←SW[7:0], go to WAIT_Y.
  - WAIT_Y: LED=synced SW[7:0]. stb_rise → y1←SW[7:0], go to CALC_X.
  - CALC_X: x2 register written; next cycle goes to CALC_Y.
  - CALC_Y: y2 register written; next cycle goes to SHOW_X.
  - SHOW_X: LED=x2. stb_rise → SHOW_Y.
  - SHOW_Y: LED=y2. stb_fall → WAIT_X. x1, y1, x2, y2 are retained until overwritten.
- Strobe level on entry is ignored; only edges count.
  - SW[8] still high when entering WAIT_Y: no capture until it falls and rises again.
  - SW[8] fall while in SHOW_X: ignored.
- Debounced SW[9]=0 in any state → IDLE on the next cycle. LED=0, Valid=0, operand registers unchanged. This overrides every strobe event in the same cycle.
- Arithmetic: signed, 10-bit intermediate, >>> is the arithmetic (floor) shift.
  - x2 = (x1>>>1) + (x1>>>2) + (y1>>>1) + 20
  - y2 = (y1>>>1) + (y1>>>2) + ((−x1)>>>1) − 20
  - −x1 is formed in 10 bits, so x1 = −128 gives +128.
  - Result is the low 8 bits; wrap-around is silent, with no saturation or flag.
- Reset: state IDLE; LED=0, Valid=0, Busy=0; x1, y1, x2, y2 = 0; synchroniser and debounce state cleared, debounced levels = 0. Reset mid-sequence discards partial operands.

## Timing
- SW change to debounced level: 2 (sync) + DEBOUNCE_CYCLES cycles. stb_rise/stb_fall assert in that same cycle.
- Capture occurs on the stb_rise cycle using the SW[7:0] synchronised value of that cycle. The operator must hold SW[7:0] stable across the strobe.
- After the y1 capture edge:
  - edge+1: CALC_X, Busy=1
  - edge+2: CALC_Y
  - edge+3: SHOW_X, LED=x2, Valid=1
- All outputs are registered. LED changes one cycle after a state change; no combinational SW→LED path.
- Back-to-back transforms need no IDLE visit while SW[9] stays high.

## Test plan
- Reset with SW=0 → LED=0, Valid=0, Busy=0; hold SW[9]=0 and pulse SW[8] 3× → LED stays 0, state IDLE.
- SW[9]=1, x1=4, strobe, y1=6, strobe → after CALC, LED=26 (0x1A), Valid=1; SW[8]=1 → LED=−18 (0xEE); SW[8]=0 → WAIT_X.
- Back-to-back without dropping SW[9]:
  - (40,21) → 60 / −25
  - (20,55) → 62 / 10
  - (11,2) → 28 / −25
  - (4,6) → 26 / −18
- Negative and wrap cases:
  - (−8,−4) → 12 / −19
  - (127,127) → x2=0xB1 (−79), y2=10
- SW[8] glitch shorter than DEBOUNCE_CYCLES during WAIT_X → no capture. SW[8] glitch during SHOW_X → LED stays x2.
- SW[9] dropped during WAIT_Y, and separately Reset asserted during CALC_X → IDLE, LED=0, Valid=0. The next full sequence (4,6) gives 26 / −18.
